toycpu_mem_ctrl: RTL and testbench
==================================

# toycpu_mem_ctrl

Program-memory owner and run controller for the 4-bit toy CPU. Holds the 16×8 program/data memory, serves the CPU's fetch/load/store bus, and shares the memory with a byte-wide host command port used to load programs, read back results, and start, halt, single-step or reset the CPU. Sits between the chip top-level pins and the CPU core. It drives the CPU's reset and a clock-enable for the CPU clock gate.

## Interface
Parameters:
- `AW`, 4: memory address width (depth = 2**AW).
- `DW`, 8: memory word width.
- `CRST_CYC`, 2: CPU reset pulse length in cycles.

Ports:
- `clk`  in  1  system clock; the CPU's gated clock derives from it.
- `rst_n`  in  1  synchronous, active-low reset.
- `host_valid`  in  1  host command/data byte valid.
- `host_data`  in  8  host byte.
- `host_ready`  out  1  byte accepted when `host_valid & host_ready`.
- `host_rvalid`  out  1  one-cycle pulse; `host_rdata` is valid.
- `host_rdata`  out  8  read-back data.
- `host_err`  out  1  one-cycle pulse on a rejected command.
- `running`  out  1  the CPU is free-running.
- `cpu_rst`  out  1  active-high reset to the CPU.
- `cpu_clk_en`  out  1  enable for the CPU clock gate.
- `cpu_addr`  in  AW  CPU memory address.
- `cpu_we`  in  1  CPU store strobe.
- `cpu_wdata`  in  DW  CPU store data.
- `cpu_rdata`  out  DW  combinational read of `mem[cpu_addr]`.

## Operation
- Host commands: the high nibble is the opcode and the low nibble is `n`.
  - `0x1n` WRITE: the next byte is written to `mem[n]`.
  - `0x2n` READ: returns `mem[n]`.
  - `0x30` RUN.
  - `0x31` HALT.
  - `0x32` STEP.
  - `0x33` CPURST.
  - Any other byte pulses `host_err` and is dropped.
- States:
  - CRST: `cpu_rst=1`, `cpu_clk_en=1` for `CRST_CYC` cycles, then HALT.
  - HALT: `cpu_clk_en=0`. All commands are legal.
  - WDATA: waits for the data byte of a WRITE.
  - RUN: `cpu_clk_en=1`, `running=1`.
  - STEP: `cpu_clk_en=1` for exactly one cycle, then HALT.
- Transitions:
  - WRITE: HALT→WDATA; WDATA→HALT when the data byte is accepted.
  - RUN: HALT→RUN.
  - HALT: RUN→HALT.
  - STEP: HALT→STEP.
  - CPURST: any state except WDATA→CRST.
  - RUN or STEP received in RUN: no effect, no error.
  - HALT received in HALT: no-op.
- Arbitration:
  - In RUN, WRITE and READ pulse `host_err` and are dropped, because the CPU owns the memory.
  - In HALT/WDATA, only the host writes memory.
  - CPU stores are honoured only when `cpu_clk_en=1`.
- CPU store: on a rising edge with `cpu_we & cpu_clk_en`, `mem[cpu_addr] <= cpu_wdata`.
- WDATA accepts any byte value as data; commands are not decoded in WDATA.
- Reset (`rst_n=0`, sampled at a rising edge):
  - All memory words become 0x00.
  - State goes to CRST.
  - `host_ready=0`, `host_rvalid=0`, `host_err=0`, `running=0`, `host_rdata=0x00`.
  - `cpu_rst=1`, `cpu_clk_en=1`.
  - Reset mid-WRITE discards the pending address.

## Timing
- `host_ready` is 1 in HALT, WDATA and RUN, and 0 in CRST and STEP.
- Handshake: the byte is consumed on the edge where `host_valid & host_ready`. `host_valid` may stay high across consecutive bytes.
- READ latency is 1: `host_rvalid` and `host_rdata` are asserted the cycle after acceptance. `host_rdata` holds until the next READ.
- `host_err` is asserted the cycle after the offending byte is accepted.
- Start latency: after RUN is accepted at edge k, `cpu_clk_en` is 1 from cycle k+1.
- Halt latency: after HALT is accepted at edge k, `cpu_clk_en` is 0 from cycle k+1.
- CPURST: `cpu_rst` is high for cycles k+1..k+`CRST_CYC`, then the block is in HALT.
- A WRITE followed by a same-address READ returns the new data. There is no forwarding hazard, because the write completes before the READ can be accepted.
- `cpu_rdata` is combinational, for the CPU's split-phase fetch/operand access.

## Configuration
- `TOYCPU_MEMCTRL_STEP_EN`:
  - Defined: the STEP command and STEP state exist.
  - Undefined: `0x32` is an illegal byte (`host_err` pulse), the STEP state is absent, and the FSM has four states.

## Structure
- Package `toycpu_pkg`:
  - Host opcode constants: `HC_WRITE=4'h1`, `HC_READ=4'h2`, `HC_CTRL=4'h3`.
  - Control sub-codes: RUN=0, HALT=1, STEP=2, CPURST=3.
  - FSM state enum `memctrl_state_t`.
- One sub-module, `toycpu_mem16`:
  - A reset-to-zero register array with one async read port (CPU), one sync read port (host) and one write port.
  - The write-port select (host vs CPU) is muxed in the parent.

## Test plan
- Reset release → `cpu_rst` is high for exactly 2 cycles, then HALT with `host_ready=1`; READ `0x25` returns 0x00.
- Send `0x13`, `0xA7`, then `0x23` → `host_rvalid` pulses one cycle after the READ byte, with `host_rdata=0xA7`.
- Load a program, then send `0x30`: `cpu_clk_en=1` and `running=1` from the next cycle. While running, send `0x24` → `host_err` pulse and no `host_rvalid`. Then send `0x31` → `cpu_clk_en=0` the next cycle.
- With the macro defined, in HALT send `0x32` → `cpu_clk_en` is high for exactly 1 cycle and `host_ready` is low that cycle. Without the macro, the same byte gives a `host_err` pulse.
- In RUN, the CPU drives `cpu_we=1`, `cpu_addr=0xF`, `cpu_wdata=0x05`; after HALT, READ `0x2F` returns 0x05. In HALT, `cpu_we` pulses are ignored.
- Send `0x14`, then assert `rst_n=0` for one cycle → READ `0x24` returns 0x00. Bytes `0x40` and `0xFF` → `host_err`, state unchanged.

Source files
------------

// File: rtl/toycpu_pkg.sv
// Shared constants and FSM state type for the toy CPU memory controller.
// TOYCPU_MEMCTRL_STEP_EN adds the single-step state to the state enum.
package toycpu_pkg;

    localparam logic [3:0] HC_WRITE = 4'h1;
    localparam logic [3:0] HC_READ  = 4'h2;
    localparam logic [3:0] HC_CTRL  = 4'h3;

    localparam logic [3:0] CC_RUN    = 4'h0;
    localparam logic [3:0] CC_HALT   = 4'h1;
    localparam logic [3:0] CC_STEP   = 4'h2;
    localparam logic [3:0] CC_CPURST = 4'h3;

`ifdef TOYCPU_MEMCTRL_STEP_EN
    typedef enum logic [2:0] {ST_CRST, ST_HALT, ST_WDATA, ST_RUN, ST_STEP} memctrl_state_t;
`else
    typedef enum logic [1:0] {ST_CRST, ST_HALT, ST_WDATA, ST_RUN} memctrl_state_t;
`endif

    // The CPU clock runs in every state except the two host-owned ones.
    function automatic logic clk_en_for(input memctrl_state_t s);
        return (s != ST_HALT) && (s != ST_WDATA);
    endfunction

endpackage

// File: rtl/toycpu_mem16.sv
// Reset-to-zero register file: async CPU read port, sync host read port, one write port.
module toycpu_mem16 #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] araddr_i,
    output logic [DW-1:0] ardata_o,
    input  logic          re_i,
    input  logic [AW-1:0] sraddr_i,
    output logic [DW-1:0] srdata_o
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] srdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            srdata_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[waddr_i] <= wdata_i;
            end
            // Host read data holds until the next read request.
            if (re_i) begin
                srdata_q <= mem_q[sraddr_i];
            end
        end
    end

    assign ardata_o = mem_q[araddr_i];
    assign srdata_o = srdata_q;

endmodule

// File: rtl/toycpu_mem_ctrl.sv
// Program-memory owner and run controller for the 4-bit toy CPU.
// Define TOYCPU_MEMCTRL_STEP_EN to enable the single-step (0x32) command.
module toycpu_mem_ctrl #(
    parameter int unsigned AW       = 4,
    parameter int unsigned DW       = 8,
    parameter int unsigned CRST_CYC = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          host_valid,
    input  logic [7:0]    host_data,
    output logic          host_ready,
    output logic          host_rvalid,
    output logic [7:0]    host_rdata,
    output logic          host_err,
    output logic          running,
    output logic          cpu_rst,
    output logic          cpu_clk_en,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_we,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata
);
    import toycpu_pkg::*;

    localparam int unsigned CNT_W = (CRST_CYC > 1) ? $clog2(CRST_CYC) : 1;

    memctrl_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    waddr_q, waddr_d;
    logic             host_ready_q, host_rvalid_q, host_err_q;
    logic             running_q, cpu_rst_q, cpu_clk_en_q;
    logic             accept, host_we, rd_req, err_d;
    logic [3:0]       opc, sub;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [DW-1:0]    mem_wdata, host_rd;

    assign accept = host_valid & host_ready_q;
    assign opc    = host_data[7:4];
    assign sub    = host_data[3:0];

    // Command decode and next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        waddr_d = waddr_q;
        host_we = 1'b0;
        rd_req  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_CRST: begin
                if (cnt_q == CNT_W'(CRST_CYC - 1)) begin
                    state_d = ST_HALT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WDATA: begin
                if (accept) begin
                    host_we = 1'b1;
                    state_d = ST_HALT;
                end
            end
            ST_HALT, ST_RUN: begin
                if (accept) begin
                    case (opc)
                        HC_WRITE, HC_READ: begin
                            if (state_q == ST_RUN) begin
                                err_d = 1'b1;
                            end else if (opc == HC_WRITE) begin
                                waddr_d = AW'(sub);
                                state_d = ST_WDATA;
                            end else begin
                                rd_req = 1'b1;
                            end
                        end
                        HC_CTRL: begin
                            case (sub)
                                CC_RUN:  state_d = ST_RUN;
                                CC_HALT: state_d = ST_HALT;
`ifdef TOYCPU_MEMCTRL_STEP_EN
                                CC_STEP: begin
                                    if (state_q == ST_HALT) begin
                                        state_d = ST_STEP;
                                    end
                                end
`endif
                                CC_CPURST: begin
                                    state_d = ST_CRST;
                                    cnt_d   = '0;
                                end
                                default: err_d = 1'b1;
                            endcase
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
`ifdef TOYCPU_MEMCTRL_STEP_EN
            ST_STEP: state_d = ST_HALT;
`endif
            default: state_d = ST_CRST;
        endcase
    end

    // State register; outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_CRST;
            cnt_q         <= '0;
            waddr_q       <= '0;
            host_ready_q  <= 1'b0;
            host_rvalid_q <= 1'b0;
            host_err_q    <= 1'b0;
            running_q     <= 1'b0;
            cpu_rst_q     <= 1'b1;
            cpu_clk_en_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            waddr_q       <= waddr_d;
            host_ready_q  <= (state_d == ST_HALT) || (state_d == ST_WDATA) || (state_d == ST_RUN);
            host_rvalid_q <= rd_req;
            host_err_q    <= err_d;
            running_q     <= (state_d == ST_RUN);
            cpu_rst_q     <= (state_d == ST_CRST);
            cpu_clk_en_q  <= clk_en_for(state_d);
        end
    end

    // Host and CPU never write together: the CPU clock is stopped in WDATA.
    assign mem_we    = host_we | (cpu_we & cpu_clk_en_q);
    assign mem_waddr = host_we ? waddr_q : cpu_addr;
    assign mem_wdata = host_we ? DW'(host_data) : cpu_wdata;

    toycpu_mem16 #(.AW(AW), .DW(DW)) u_mem (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (mem_we),
        .waddr_i  (mem_waddr),
        .wdata_i  (mem_wdata),
        .araddr_i (cpu_addr),
        .ardata_o (cpu_rdata),
        .re_i     (rd_req),
        .sraddr_i (AW'(sub)),
        .srdata_o (host_rd)
    );

    assign host_ready  = host_ready_q;
    assign host_rvalid = host_rvalid_q;
    assign host_rdata  = 8'(host_rd);
    assign host_err    = host_err_q;
    assign running     = running_q;
    assign cpu_rst     = cpu_rst_q;
    assign cpu_clk_en  = cpu_clk_en_q;

endmodule

// File: tb/tb_toycpu_mem_ctrl.sv
// Bench for toycpu_mem_ctrl: directed and random host bytes checked against a
// behavioural model of the command protocol and memory contents.
module tb_toycpu_mem_ctrl;

`ifdef TOYCPU_MEMCTRL_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    localparam int M_HALT  = 0;
    localparam int M_WDATA = 1;
    localparam int M_RUN   = 2;
    localparam int M_STEP  = 3;
    localparam int M_CRST  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       host_valid = 1'b0;
    logic [7:0] host_data = 8'h00;
    logic       host_ready, host_rvalid, host_err, running, cpu_rst, cpu_clk_en;
    logic [7:0] host_rdata;
    logic [3:0] cpu_addr = 4'h0;
    logic       cpu_we = 1'b0;
    logic [7:0] cpu_wdata = 8'h00;
    logic [7:0] cpu_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_m [16];
    int         st_m = M_CRST;
    logic [3:0] pend_m = 4'h0;
    logic [7:0] last_rd_m = 8'h00;

    toycpu_mem_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .host_valid  (host_valid),
        .host_data   (host_data),
        .host_ready  (host_ready),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .host_err    (host_err),
        .running     (running),
        .cpu_rst     (cpu_rst),
        .cpu_clk_en  (cpu_clk_en),
        .cpu_addr    (cpu_addr),
        .cpu_we      (cpu_we),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctrl(input string tag);
        chk({tag, "_ready"}, 32'(host_ready), 32'(st_m == M_HALT || st_m == M_WDATA || st_m == M_RUN));
        chk({tag, "_clken"}, 32'(cpu_clk_en), 32'(st_m == M_RUN || st_m == M_STEP || st_m == M_CRST));
        chk({tag, "_running"}, 32'(running), 32'(st_m == M_RUN));
        chk({tag, "_cpurst"}, 32'(cpu_rst), 32'(st_m == M_CRST));
    endtask

    // Called on the first cycle of a CPU reset pulse; follows it into HALT.
    task automatic follow_crst();
        chk("crst_c1", 32'(cpu_rst), 32'd1);
        step();
        chk("crst_c2", 32'(cpu_rst), 32'd1);
        chk("crst_c2_ready", 32'(host_ready), 32'd0);
        step();
        st_m = M_HALT;
        chk_ctrl("crst_done");
    endtask

    task automatic send(input logic [7:0] b);
        int  waited;
        bit  e_err, e_rv;
        e_err = 1'b0;
        e_rv  = 1'b0;
        host_valid = 1'b1;
        host_data  = b;
        waited = 0;
        while (!host_ready && waited < 20) begin
            step();
            waited++;
        end
        if (!host_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            host_valid = 1'b0;
            return;
        end
        step();
        host_valid = 1'b0;
        if (st_m == M_WDATA) begin
            mem_m[pend_m] = b;
            st_m = M_HALT;
        end else begin
            case (b[7:4])
                4'h1: if (st_m == M_RUN) e_err = 1'b1; else begin pend_m = b[3:0]; st_m = M_WDATA; end
                4'h2: if (st_m == M_RUN) e_err = 1'b1; else begin e_rv = 1'b1; last_rd_m = mem_m[b[3:0]]; end
                4'h3: case (b[3:0])
                    4'h0: st_m = M_RUN;
                    4'h1: st_m = M_HALT;
                    4'h2: if (!STEP_EN) e_err = 1'b1; else if (st_m == M_HALT) st_m = M_STEP;
                    4'h3: st_m = M_CRST;
                    default: e_err = 1'b1;
                endcase
                default: e_err = 1'b1;
            endcase
        end
        chk("host_err", 32'(host_err), 32'(e_err));
        chk("host_rvalid", 32'(host_rvalid), 32'(e_rv));
        chk("host_rdata", 32'(host_rdata), 32'(last_rd_m));
        chk_ctrl("after_byte");
        if (st_m == M_STEP) begin
            step();
            st_m = M_HALT;
            chk_ctrl("step_end");
        end else if (st_m == M_CRST) begin
            follow_crst();
        end
    endtask

    task automatic cpu_store(input logic [3:0] a, input logic [7:0] d);
        cpu_we    = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        step();
        cpu_we = 1'b0;
        if (st_m == M_RUN || st_m == M_STEP || st_m == M_CRST) mem_m[a] = d;
    endtask

    task automatic chk_cpu_rd(input logic [3:0] a);
        cpu_addr = a;
        #1;
        chk("cpu_rdata", 32'(cpu_rdata), 32'(mem_m[a]));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
        st_m      = M_CRST;
        last_rd_m = 8'h00;
    endtask

    initial begin
        logic [7:0] b;
        int r;
        model_reset();

        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_rvalid", 32'(host_rvalid), 32'd0);
        chk("rst_err", 32'(host_err), 32'd0);
        chk("rst_rdata", 32'(host_rdata), 32'd0);
        chk_ctrl("rst");
        follow_crst();
        send(8'h25);

        // Write then read back
        send(8'h13);
        send(8'hA7);
        send(8'h23);

        // Load a program, run, blocked access, CPU store, halt
        for (int i = 0; i < 8; i++) begin
            send(8'h10 | 8'(i));
            send(8'($urandom));
        end
        send(8'h30);
        send(8'h24);
        send(8'h30);
        cpu_store(4'hF, 8'h05);
        send(8'h31);
        send(8'h2F);
        cpu_store(4'hE, 8'h99);
        send(8'h2E);
        chk_cpu_rd(4'hF);

        // Single step (or illegal byte), CPU reset from HALT and from RUN
        send(8'h32);
        send(8'h33);
        send(8'h30);
        send(8'h32);
        send(8'h33);
        send(8'h21);

        // Random traffic
        for (int it = 0; it < 250; it++) begin
            r = int'($urandom_range(0, 99));
            if (r < 35) begin
                send(8'h10 | 8'($urandom_range(0, 15)));
                send(8'($urandom));
            end else if (r < 60) begin
                send(8'h20 | 8'($urandom_range(0, 15)));
            end else if (r < 70) begin
                b = {4'($urandom_range(4, 15)), 4'($urandom)};
                send(b);
            end else if (r < 85) begin
                send(8'h30 | 8'($urandom_range(0, 3)));
            end else if (r < 95) begin
                cpu_store(4'($urandom), 8'($urandom));
            end else begin
                chk_cpu_rd(4'($urandom));
            end
        end
        send(8'h31);
        for (int i = 0; i < 16; i++) send(8'h20 | 8'(i));

        // Reset in the middle of a WRITE discards the pending address
        send(8'h14);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        model_reset();
        chk("midrst_rdata", 32'(host_rdata), 32'd0);
        chk_ctrl("midrst");
        follow_crst();
        send(8'h24);
        send(8'h40);
        send(8'hFF);
        send(8'h24);
        chk_cpu_rd(4'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
